// File: rtl/radio_txrx_sequencer.sv
// Radio daughterboard Tx/Rx turn-on/turn-off sequencer with settling delays.
// Optional Tx gain ramp in TX_PA: define TXRX_SEQ_GAIN_RAMP_EN.
module radio_txrx_sequencer #(
  parameter int DLY_W     = 8,
  parameter int GAIN_STEP = 4
) (
  input  logic             converter_clock_in,
  input  logic             reset_n,
  input  logic             tx_req,
  input  logic             rx_req,
  input  logic             band_5g,
  input  logic             ant_sel,
  input  logic [5:0]       tx_gain_target,
  input  logic [DLY_W-1:0] dly_ant,
  input  logic [DLY_W-1:0] dly_tx_pa,
  input  logic [DLY_W-1:0] dly_rx_hp,
  output logic             controller_TxEn,
  output logic             controller_RxEn,
  output logic             controller_RxHP,
  output logic             controller_24PA,
  output logic             controller_5PA,
  output logic [1:0]       controller_ANTSW,
  output logic [5:0]       user_Tx_gain,
  output logic             tx_ready,
  output logic             rx_ready,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, TX_ANT, TX_EN, TX_PA, TX_ACTIVE,
    TX_OFF, RX_ANT, RX_HP, RX_ACTIVE
  } state_t;

  state_t           r_state;
  logic [DLY_W-1:0] r_cnt;
  logic             r_band;
  logic [5:0]       r_tgt;

  logic w_ant_done;
  logic w_pa_done;
  logic w_hp_done;
  logic w_tx_abort;

  assign w_ant_done = (r_cnt == dly_ant);
  assign w_pa_done  = (r_cnt == dly_tx_pa);
  assign w_hp_done  = (r_cnt == dly_rx_hp);
  assign w_tx_abort = !tx_req &&
    (r_state inside {TX_ANT, TX_EN, TX_PA, TX_ACTIVE});

`ifdef TXRX_SEQ_GAIN_RAMP_EN
  localparam int SW = (GAIN_STEP > 1) ? $clog2(GAIN_STEP) : 1;
  logic [SW-1:0] r_step;
`else
  logic w_unused_step;
  assign w_unused_step = (GAIN_STEP != 0);
`endif

  always_ff @(posedge converter_clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_band           <= 1'b0;
      r_tgt            <= '0;
      controller_TxEn  <= 1'b0;
      controller_RxEn  <= 1'b0;
      controller_RxHP  <= 1'b0;
      controller_24PA  <= 1'b0;
      controller_5PA   <= 1'b0;
      controller_ANTSW <= 2'b01;
      user_Tx_gain     <= '0;
      tx_ready         <= 1'b0;
      rx_ready         <= 1'b0;
      busy             <= 1'b0;
`ifdef TXRX_SEQ_GAIN_RAMP_EN
      r_step           <= '0;
`endif
    end else if (w_tx_abort) begin
      // PA off first; TxEn stays as-is until TX_OFF has elapsed
      r_state         <= TX_OFF;
      r_cnt           <= '0;
      controller_24PA <= 1'b0;
      controller_5PA  <= 1'b0;
      user_Tx_gain    <= '0;
      tx_ready        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (tx_req || rx_req) begin
            r_state          <= tx_req ? TX_ANT : RX_ANT;
            busy             <= 1'b1;
            r_band           <= band_5g;
            r_tgt            <= tx_gain_target;
            controller_ANTSW <= ant_sel ? 2'b10 : 2'b01;
          end
        end
        TX_ANT: begin
          if (w_ant_done) begin
            r_state         <= TX_EN;
            r_cnt           <= '0;
            controller_TxEn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_EN: begin
          if (w_pa_done) begin
            r_state         <= TX_PA;
            r_cnt           <= '0;
            controller_24PA <= !r_band;
            controller_5PA  <= r_band;
`ifdef TXRX_SEQ_GAIN_RAMP_EN
            user_Tx_gain    <= '0;
            r_step          <= '0;
`else
            user_Tx_gain    <= r_tgt;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_PA: begin
`ifdef TXRX_SEQ_GAIN_RAMP_EN
          if (user_Tx_gain == r_tgt) begin
            r_state  <= TX_ACTIVE;
            tx_ready <= 1'b1;
          end else if (r_step == SW'(GAIN_STEP - 1)) begin
            user_Tx_gain <= user_Tx_gain + 1'b1;
            r_step       <= '0;
          end else begin
            r_step <= r_step + 1'b1;
          end
`else
          r_state  <= TX_ACTIVE;
          tx_ready <= 1'b1;
`endif
        end
        TX_ACTIVE: begin
        end
        TX_OFF: begin
          if (w_pa_done) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            controller_TxEn <= 1'b0;
            busy            <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_ANT: begin
          if (!rx_req) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (w_ant_done) begin
            r_state         <= RX_HP;
            r_cnt           <= '0;
            controller_RxEn <= 1'b1;
            controller_RxHP <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_HP: begin
          if (!rx_req) begin
            r_state         <= IDLE;
            controller_RxEn <= 1'b0;
            controller_RxHP <= 1'b0;
            busy            <= 1'b0;
          end else if (w_hp_done) begin
            r_state         <= RX_ACTIVE;
            controller_RxHP <= 1'b0;
            rx_ready        <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_ACTIVE: begin
          if (!rx_req) begin
            r_state         <= IDLE;
            controller_RxEn <= 1'b0;
            rx_ready        <= 1'b0;
            busy            <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radio_txrx_sequencer.sv
// Directed self-checking bench for radio_txrx_sequencer.
// Build with TXRX_SEQ_GAIN_RAMP_EN to exercise the gain ramp.
module tb_radio_txrx_sequencer;

`ifdef TXRX_SEQ_GAIN_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_req = 1'b0;
  logic       rx_req = 1'b0;
  logic       band_5g = 1'b0;
  logic       ant_sel = 1'b0;
  logic [5:0] tx_gain_target = '0;
  logic [7:0] dly_ant = '0;
  logic [7:0] dly_tx_pa = '0;
  logic [7:0] dly_rx_hp = '0;
  logic       TxEn, RxEn, RxHP, PA24, PA5;
  logic [1:0] ANTSW;
  logic [5:0] gain;
  logic       tx_ready, rx_ready, busy;

  int n_run = 0;
  int n_fail = 0;
  int edge_n = 0;
  bit overlap = 1'b0;

  radio_txrx_sequencer #(.DLY_W(8), .GAIN_STEP(4)) dut (
    .converter_clock_in(clk),
    .reset_n(reset_n),
    .tx_req(tx_req),
    .rx_req(rx_req),
    .band_5g(band_5g),
    .ant_sel(ant_sel),
    .tx_gain_target(tx_gain_target),
    .dly_ant(dly_ant),
    .dly_tx_pa(dly_tx_pa),
    .dly_rx_hp(dly_rx_hp),
    .controller_TxEn(TxEn),
    .controller_RxEn(RxEn),
    .controller_RxHP(RxHP),
    .controller_24PA(PA24),
    .controller_5PA(PA5),
    .controller_ANTSW(ANTSW),
    .user_Tx_gain(gain),
    .tx_ready(tx_ready),
    .rx_ready(rx_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (TxEn && RxEn) overlap = 1'b1;

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic go(input int n);
    while (edge_n < n) step();
  endtask

  task automatic cleanup();
    int k;
    tx_req = 1'b0;
    rx_req = 1'b0;
    k = 0;
    while (busy && k < 64) begin
      step();
      k++;
    end
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cleanup_idle busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_run++;
    if ({TxEn, RxEn, RxHP, PA24, PA5} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl got %b exp 00000",
               {TxEn, RxEn, RxHP, PA24, PA5});
    end
    n_run++;
    if (ANTSW !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_antsw got %b exp 01", ANTSW);
    end
    n_run++;
    if ({gain, tx_ready, rx_ready, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_misc got %b exp 0",
               {gain, tx_ready, rx_ready, busy});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_tx_up();
    dly_ant = 8'd2;
    dly_tx_pa = 8'd3;
    tx_gain_target = 6'd5;
    band_5g = 1'b0;
    ant_sel = 1'b1;
    step();
    edge_n = 0;
    tx_req = 1'b1;
    go(1);
    tx_gain_target = 6'd63;
    n_run++;
    if (ANTSW !== 2'b10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_antsw@1 got %b/%b exp 10/1", ANTSW, busy);
    end
    go(2);
    ant_sel = 1'b0;
    go(3);
    n_run++;
    if (TxEn !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_en@3 got %b exp 0", TxEn);
    end
    go(4);
    n_run++;
    if (TxEn !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_en@4 got %b exp 1", TxEn);
    end
    go(7);
    n_run++;
    if (PA24 !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_pa@7 got %b exp 0", PA24);
    end
    go(8);
    n_run++;
    if (PA24 !== 1'b1 || PA5 !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_pa@8 got %b%b exp 10", PA24, PA5);
    end
    n_run++;
    if (gain !== (RAMP ? 6'd0 : 6'd5)) begin
      n_fail++;
      $display("FAIL tx_gain@8 got %0d exp %0d", gain, RAMP ? 0 : 5);
    end
    go(9);
    n_run++;
    if (tx_ready !== !RAMP) begin
      n_fail++;
      $display("FAIL tx_ready@9 got %b exp %b", tx_ready, !RAMP);
    end
    n_run++;
    if (ANTSW !== 2'b10 || PA5 !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_hold@9 got %b/%b exp 10/0", ANTSW, PA5);
    end
  endtask

  task automatic test_tx_down();
    go(20);
    tx_req = 1'b0;
    go(21);
    n_run++;
    if ({PA24, PA5, gain, tx_ready} !== 9'b0) begin
      n_fail++;
      $display("FAIL down@21 got %b exp 0", {PA24, PA5, gain, tx_ready});
    end
    n_run++;
    if (TxEn !== 1'b1) begin
      n_fail++;
      $display("FAIL down_txen@21 got %b exp 1", TxEn);
    end
    go(24);
    n_run++;
    if (TxEn !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL down@24 got %b/%b exp 1/1", TxEn, busy);
    end
    go(25);
    n_run++;
    if (TxEn !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL down@25 got %b/%b exp 0/0", TxEn, busy);
    end
  endtask

  task automatic test_rx_and_priority();
    dly_ant = 8'd0;
    dly_rx_hp = 8'd10;
    ant_sel = 1'b0;
    step();
    edge_n = 0;
    rx_req = 1'b1;
    go(1);
    n_run++;
    if (busy !== 1'b1 || RxEn !== 1'b0 || ANTSW !== 2'b01) begin
      n_fail++;
      $display("FAIL rx@1 got %b%b%b exp 1 0 01", busy, RxEn, ANTSW);
    end
    go(2);
    n_run++;
    if ({RxEn, RxHP, TxEn} !== 3'b110) begin
      n_fail++;
      $display("FAIL rx@2 got %b exp 110", {RxEn, RxHP, TxEn});
    end
    go(12);
    n_run++;
    if (RxHP !== 1'b1 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rx@12 got %b%b exp 10", RxHP, rx_ready);
    end
    go(13);
    n_run++;
    if ({RxEn, RxHP, rx_ready, TxEn} !== 4'b1010) begin
      n_fail++;
      $display("FAIL rx@13 got %b exp 1010",
               {RxEn, RxHP, rx_ready, TxEn});
    end
    go(15);
    tx_req = 1'b1;
    ant_sel = 1'b1;
    go(20);
    n_run++;
    if (rx_ready !== 1'b1 || TxEn !== 1'b0 || ANTSW !== 2'b01) begin
      n_fail++;
      $display("FAIL prio@20 got %b%b%b exp 1 0 01",
               rx_ready, TxEn, ANTSW);
    end
    rx_req = 1'b0;
    go(21);
    n_run++;
    if ({RxEn, rx_ready, busy, TxEn} !== 4'b0) begin
      n_fail++;
      $display("FAIL prio@21 got %b exp 0000",
               {RxEn, rx_ready, busy, TxEn});
    end
    go(22);
    n_run++;
    if (busy !== 1'b1 || ANTSW !== 2'b10 || TxEn !== 1'b0) begin
      n_fail++;
      $display("FAIL prio@22 got %b%b%b exp 1 10 0", busy, ANTSW, TxEn);
    end
    go(23);
    n_run++;
    if (TxEn !== 1'b1) begin
      n_fail++;
      $display("FAIL prio@23 got %b exp 1", TxEn);
    end
    cleanup();
  endtask

  task automatic test_both_req();
    dly_ant = 8'd1;
    step();
    edge_n = 0;
    tx_req = 1'b1;
    rx_req = 1'b1;
    go(2);
    n_run++;
    if (TxEn !== 1'b0 || RxEn !== 1'b0) begin
      n_fail++;
      $display("FAIL both@2 got %b%b exp 00", TxEn, RxEn);
    end
    go(3);
    n_run++;
    if (TxEn !== 1'b1 || RxEn !== 1'b0) begin
      n_fail++;
      $display("FAIL both@3 got %b%b exp 10", TxEn, RxEn);
    end
    cleanup();
  endtask

  task automatic test_reset_mid();
    dly_ant = 8'd0;
    dly_tx_pa = 8'd0;
    tx_gain_target = 6'd7;
    band_5g = 1'b1;
    ant_sel = 1'b1;
    step();
    edge_n = 0;
    tx_req = 1'b1;
    go(3);
    n_run++;
    if ({TxEn, PA5, PA24} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid@3 got %b exp 110", {TxEn, PA5, PA24});
    end
    n_run++;
    if (gain !== (RAMP ? 6'd0 : 6'd7)) begin
      n_fail++;
      $display("FAIL mid_gain@3 got %0d exp %0d", gain, RAMP ? 0 : 7);
    end
    #1 reset_n = 1'b0;
    #1;
    n_run++;
    if ({TxEn, PA5, PA24, gain, tx_ready, busy} !== 11'b0) begin
      n_fail++;
      $display("FAIL mid_rst got %b exp 0",
               {TxEn, PA5, PA24, gain, tx_ready, busy});
    end
    n_run++;
    if (ANTSW !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_rst_antsw got %b exp 01", ANTSW);
    end
    #1 reset_n = 1'b1;
    edge_n = 0;
    go(1);
    n_run++;
    if (busy !== 1'b1 || ANTSW !== 2'b10 || TxEn !== 1'b0) begin
      n_fail++;
      $display("FAIL restart@1 got %b%b%b exp 1 10 0", busy, ANTSW, TxEn);
    end
    go(2);
    n_run++;
    if (TxEn !== 1'b1) begin
      n_fail++;
      $display("FAIL restart@2 got %b exp 1", TxEn);
    end
    cleanup();
  endtask

`ifdef TXRX_SEQ_GAIN_RAMP_EN
  task automatic test_ramp();
    dly_ant = 8'd0;
    dly_tx_pa = 8'd0;
    tx_gain_target = 6'd3;
    band_5g = 1'b0;
    step();
    edge_n = 0;
    tx_req = 1'b1;
    go(3);
    n_run++;
    if (PA24 !== 1'b1 || gain !== 6'd0) begin
      n_fail++;
      $display("FAIL ramp@3 got %b/%0d exp 1/0", PA24, gain);
    end
    go(6);
    n_run++;
    if (gain !== 6'd0) begin
      n_fail++;
      $display("FAIL ramp@6 got %0d exp 0", gain);
    end
    go(7);
    n_run++;
    if (gain !== 6'd1) begin
      n_fail++;
      $display("FAIL ramp@7 got %0d exp 1", gain);
    end
    go(11);
    n_run++;
    if (gain !== 6'd2) begin
      n_fail++;
      $display("FAIL ramp@11 got %0d exp 2", gain);
    end
    go(15);
    n_run++;
    if (gain !== 6'd3 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp@15 got %0d/%b exp 3/0", gain, tx_ready);
    end
    go(16);
    n_run++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp@16 got %b exp 1", tx_ready);
    end
    cleanup();
  endtask
`endif

  initial begin
    test_reset();
    test_tx_up();
    test_tx_down();
    test_rx_and_priority();
    test_both_req();
    test_reset_mid();
`ifdef TXRX_SEQ_GAIN_RAMP_EN
    test_ramp();
`endif
    n_run++;
    if (overlap !== 1'b0) begin
      n_fail++;
      $display("FAIL txen_rxen_overlap got %b exp 0", overlap);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/radio_txrx_sequencer.md
# radio_txrx_sequencer

Sequences a radio daughterboard through safe transmit and receive turn-on and turn-off. It drives the radio control lines in a fixed order with programmable settling delays: antenna switch, TxEn/RxEn, RxHP, PA enables and the Tx gain word. It sits between the user/MAC logic, which raises level requests, and the radio bridge controller inputs. A PA is never enabled before TxEn has settled, and TxEn is never dropped while a PA is on.

## Interface
- DLY_W, 8: width of delay inputs.
- GAIN_STEP, 4: cycles per Tx gain increment (used only with ramp enabled).

- converter_clock_in  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- tx_req  in  1  level; hold high to transmit.
- rx_req  in  1  level; hold high to receive.
- band_5g  in  1  0 = 2.4 GHz PA, 1 = 5 GHz PA; sampled on leaving IDLE.
- ant_sel  in  1  0 = antenna A, 1 = antenna B; sampled on leaving IDLE.
- tx_gain_target  in  6  final Tx gain; sampled on leaving IDLE.
- dly_ant  in  DLY_W  antenna switch settle delay.
- dly_tx_pa  in  DLY_W  TxEn-to-PA delay; also used as PA-off-to-TxEn-off delay.
- dly_rx_hp  in  DLY_W  RxHP high duration.
- controller_TxEn, controller_RxEn, controller_RxHP, controller_24PA, controller_5PA  out  1 each  radio control, active high.
- controller_ANTSW  out  2  antenna A = 2'b01, B = 2'b10.
- user_Tx_gain  out  6  Tx gain word to radio bridge.
- tx_ready, rx_ready  out  1 each  path fully up.
- busy  out  1  state != IDLE.

## Operation
- All outputs are registered.
- Reset values: every output is 0, except controller_ANTSW, which resets to 2'b01.
- The FSM has these states: IDLE, TX_ANT, TX_EN, TX_PA, TX_ACTIVE, TX_OFF, RX_ANT, RX_HP, RX_ACTIVE.
- A wait state programmed with value N lasts exactly N+1 cycles. N = 0 gives 1 cycle.
- IDLE:
  - tx_req=1 → TX_ANT. tx_req has priority when tx_req and rx_req are both high.
  - Else rx_req=1 → RX_ANT.
  - On leaving IDLE, band_5g, ant_sel and tx_gain_target are latched, and ANTSW is updated.
- TX_ANT (dly_ant): ANTSW driven from the latched selection → TX_EN.
- TX_EN (dly_tx_pa): TxEn=1 → TX_PA.
- TX_PA: the PA for the latched band is set to 1, the other PA stays 0.
  - Without ramp: gain = target; state lasts 1 cycle.
  - With ramp: see Configuration.
  - → TX_ACTIVE.
- TX_ACTIVE: tx_ready=1. Leaves when tx_req drops → TX_OFF.
- TX_OFF (dly_tx_pa): both PAs = 0, gain = 0, tx_ready = 0, TxEn held 1 → IDLE, where TxEn = 0.
- RX_ANT (dly_ant) → RX_HP.
- RX_HP (dly_rx_hp): RxEn=1, RxHP=1 → RX_ACTIVE.
- RX_ACTIVE: RxHP=0, rx_ready=1. When rx_req drops → IDLE; RxEn and rx_ready clear on entering IDLE.
- Abort during TX_ANT, TX_EN or TX_PA (tx_req low): go to TX_OFF next cycle.
- Abort during RX_ANT or RX_HP (rx_req low): go to IDLE.
- A tx_req while the Rx path is up does not pre-empt it. Tx is served from IDLE after rx_req drops.
- TxEn and RxEn are never high simultaneously.
- ANTSW changes only on leaving IDLE.

## Timing
- The request is sampled at edge k.
- Tx:
  - ANTSW valid from k+1.
  - TxEn from k+dly_ant+2.
  - PA from k+dly_ant+dly_tx_pa+3.
  - tx_ready from k+dly_ant+dly_tx_pa+4 (no ramp).
- Tx teardown: tx_req low sampled at edge j in TX_ACTIVE → PA=0 and gain=0 at j+1; TxEn=0 at j+dly_tx_pa+2.
- Rx:
  - RxEn and RxHP from k+dly_ant+2.
  - RxHP low and rx_ready high from k+dly_ant+dly_rx_hp+3.
- Delay inputs are sampled each cycle while counting. Changing them mid-wait is undefined.
- Asserting reset_n low mid-sequence forces reset values immediately and asynchronously, including PA off.

## Configuration
- TXRX_SEQ_GAIN_RAMP_EN defined:
  - TX_PA is entered with gain 0.
  - Gain increments by 1 every GAIN_STEP cycles.
  - Leaves TX_PA on the edge after gain == target, so TX_PA lasts target×GAIN_STEP+1 cycles.
  - target = 0 behaves like no-ramp.
- TXRX_SEQ_GAIN_RAMP_EN undefined: gain jumps to target on entering TX_PA; no ramp counter is built.

## Test plan
- No ramp; dly_ant=2, dly_tx_pa=3, target=5, band_5g=0, ant_sel=1; tx_req at edge 0 → ANTSW=2'b10 at 1, TxEn at 4, 24PA=1 and gain=5 at 8, tx_ready at 9; 5PA stays 0.
- From the Tx-up state above, drop tx_req at edge 20 → PA=0 and gain=0 at 21; TxEn=0 at 25; busy=0 at 25.
- Rx with dly_ant=0, dly_rx_hp=10; rx_req at edge 0 → RxEn=RxHP=1 at 2; RxHP=0 and rx_ready=1 at 13; TxEn stays 0 throughout.
- tx_req and rx_req rise together → Tx path taken. Raise tx_req during RX_ACTIVE → ignored until rx_req drops, then Tx sequence starts from IDLE.
- Ramp enabled, GAIN_STEP=4, target=3 → gain steps 0,1,2,3 at 4-cycle intervals; tx_ready 13 cycles after PA on.
- reset_n low during TX_PA → TxEn, PAs, gain, ready all 0 immediately; ANTSW=2'b01; next request restarts from IDLE.
